// File: rtl/avmm_pkg.sv
// Shared definitions for the Avalon-MM command master: FSM encoding,
// data width and the default abort timeout.
package avmm_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/avmm_cmd_master.sv
// Single-outstanding command-to-Avalon-MM bridge with a waitrequest timeout.
// All bus outputs are registered and stay stable for the whole transfer.
module avmm_cmd_master
    import avmm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    input  logic [3:0]        cmd_byteenable,

    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error
);

    // Counter value seen during the TIMEOUT-th stalled bus cycle.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       bus_done;
    logic       bus_abort;

    assign cmd_ready = (state == ST_IDLE);
    assign bus_done  = (state == ST_BUS) && !avm_waitrequest;
    assign bus_abort = (state == ST_BUS) && avm_waitrequest && (wait_cnt == LAST_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid)              state_nxt = ST_BUS;
            ST_BUS:  if (bus_done || bus_abort)  state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)              state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            avm_write_n    <= 1'b1;
            wait_cnt       <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        avm_address    <= cmd_address;
                        avm_writedata  <= cmd_writedata;
                        avm_byteenable <= cmd_byteenable;
                        avm_chipselect <= 1'b1;
                        avm_read       <= ~cmd_write;
                        avm_write_n    <= ~cmd_write;
                        wait_cnt       <= '0;
                    end
                end
                ST_BUS: begin
                    if (avm_waitrequest) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                    // Completion is checked first so a late-falling waitrequest beats the abort.
                    if (bus_done || bus_abort) begin
                        avm_chipselect <= 1'b0;
                        avm_read       <= 1'b0;
                        avm_write_n    <= 1'b1;
                        rsp_valid      <= 1'b1;
                        rsp_error      <= !bus_done;
                        rsp_data       <= (bus_done && avm_read) ? avm_readdata : '0;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Directed self-checking bench for avmm_cmd_master with a scripted slave.
module tb_avmm_cmd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic [3:0]  cmd_byteenable;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_read;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    avmm_cmd_master #(.ADDR_W(2), .TIMEOUT(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_address     (cmd_address),
        .cmd_writedata   (cmd_writedata),
        .cmd_byteenable  (cmd_byteenable),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_read        (avm_read),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_error       (rsp_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a negedge with the DUT idle. nwait = stalled strobe cycles before readdata is valid.
    task automatic run_xfer(input string tag, input logic wr, input logic [1:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, input int nwait,
                            input logic [31:0] rd, input int exp_cycles,
                            input logic [31:0] exp_data, input logic exp_err,
                            input int hold, input logic keep_valid);
        int cnt;
        check({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid      = 1'b1;
        cmd_write      = wr;
        cmd_address    = addr;
        cmd_writedata  = wd;
        cmd_byteenable = be;
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) cmd_valid = 1'b0;
        check({tag, "_cs"},   32'(avm_chipselect), 32'd1);
        check({tag, "_addr"}, 32'(avm_address), 32'(addr));
        check({tag, "_wd"},   avm_writedata, wd);
        check({tag, "_be"},   32'(avm_byteenable), 32'(be));
        check({tag, "_rd_strobe"}, 32'(avm_read), 32'(!wr));
        cnt = 0;
        while ((wr ? !avm_write_n : avm_read) && cnt < 40) begin
            if (cmd_ready !== 1'b0) check({tag, "_ready_bus"}, 32'(cmd_ready), 32'd0);
            cnt++;
            avm_waitrequest = (cnt <= nwait);
            avm_readdata    = (cnt <= nwait) ? 32'hDEAD_BEEF : rd;
            @(negedge clk);
        end
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hDEAD_BEEF;
        check({tag, "_strobe_cycles"}, 32'(cnt), 32'(exp_cycles));
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_data"},  rsp_data, exp_data);
        check({tag, "_rsp_error"}, 32'(rsp_error), 32'(exp_err));
        check({tag, "_bus_idle"},  {29'd0, avm_chipselect, avm_read, avm_write_n}, 32'd1);
        check({tag, "_ready_resp"}, 32'(cmd_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_data"},  rsp_data, exp_data);
            check({tag, "_hold_err"},   32'(rsp_error), 32'(exp_err));
            check({tag, "_hold_ready"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_address = '0;
        cmd_writedata = '0;
        cmd_byteenable = '0;
        avm_readdata = '0;
        avm_waitrequest = 1'b1;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_outputs", {avm_writedata[15:0], 4'(avm_byteenable), 2'(avm_address), 5'd0,
                              avm_chipselect, avm_read, avm_write_n, rsp_valid, rsp_error}, 32'h0000_0004);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_writedata", avm_writedata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // zero-wait write, zero-wait-ish read, timeout, late completion
        run_xfer("wr0",   1'b1, 2'd0, 32'h0000_03FF, 4'hF, 0,   32'h0,         1,  32'h0,         1'b0, 0, 1'b0);
        run_xfer("rd3",   1'b0, 2'd0, 32'h1234_5678, 4'hF, 3,   32'h0000_0155, 4,  32'h0000_0155, 1'b0, 0, 1'b0);
        run_xfer("tmo",   1'b0, 2'd1, 32'h0,         4'h3, 100, 32'h0000_0AAA, 16, 32'h0,         1'b1, 0, 1'b0);
        run_xfer("late",  1'b0, 2'd2, 32'h0,         4'h1, 15,  32'hCAFE_0016, 16, 32'hCAFE_0016, 1'b0, 0, 1'b0);
        run_xfer("wrtmo", 1'b1, 2'd3, 32'hA5A5_5A5A, 4'h8, 100, 32'h0,         16, 32'h0,         1'b1, 0, 1'b0);

        // back-pressured response with cmd_valid held; the follow-up is accepted on the next edge
        run_xfer("bp",    1'b0, 2'd3, 32'h0,         4'hF, 1,   32'h8765_4321, 2,  32'h8765_4321, 1'b0, 5, 1'b1);
        run_xfer("bp2",   1'b1, 2'd1, 32'h0F0F_0F0F, 4'h5, 2,   32'h0,         3,  32'h0,         1'b0, 0, 1'b0);

        // reset in the middle of a stalled read
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_address = 2'd2;
        cmd_byteenable = 4'hC;
        avm_waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_read_on", 32'(avm_read), 32'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_strobes", {29'd0, avm_chipselect, avm_read, avm_write_n}, 32'd1);
        check("mid_rst_addr", 32'(avm_address), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(rsp_valid), 32'd0);
            check("post_rst_ready", 32'(cmd_ready), 32'd1);
            check("post_rst_cs", 32'(avm_chipselect), 32'd0);
        end

        run_xfer("after", 1'b0, 2'd1, 32'h0, 4'hF, 0, 32'h0000_7777, 1, 32'h0000_7777, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/avmm_cmd_master.md
AVMM_CMD_MASTER -- requirements
Module: avmm_cmd_master

Interface
REQ-001 Parameter ADDR_W, default 2: Avalon-MM word-address width.
REQ-002 Parameter TIMEOUT, default 16: maximum bus cycles per transfer before abort; legal range 2..255.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  local command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_address  in  ADDR_W  target word address.
REQ-009 cmd_writedata  in  32  write payload.
REQ-010 cmd_byteenable  in  4  byte lanes for the transfer.
REQ-011 avm_address  out  ADDR_W  bus address.
REQ-012 avm_chipselect  out  1  asserted for the whole transfer.
REQ-013 avm_read  out  1  read strobe (active-high).
REQ-014 avm_write_n  out  1  write strobe (active-low).
REQ-015 avm_writedata  out  32  bus write data.
REQ-016 avm_byteenable  out  4  bus byte enables.
REQ-017 avm_readdata  in  32  slave read data, valid in the cycle waitrequest is low.
REQ-018 avm_waitrequest  in  1  slave stall.
REQ-019 rsp_valid  out  1  response available.
REQ-020 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-021 rsp_data  out  32  read data; 0 for writes and aborts.
REQ-022 rsp_error  out  1  1 = transfer aborted by timeout.

Function
REQ-023 FSM states IDLE, BUS, RESP; at most one transfer outstanding.
REQ-024 IDLE: cmd_ready=1; on acceptance, register address/data/byteenable/write and go to BUS.
REQ-025 BUS and RESP: cmd_ready=0.
REQ-026 BUS: chipselect=1; avm_read=~write or avm_write_n=~write; all bus outputs come from registers and stay stable until completion.
REQ-027 Strobes assert in the cycle after acceptance, so minimum latency is acceptance edge N, strobe in cycle N+1, and rsp_valid in cycle N+2.
REQ-028 Completion: at the edge where the strobe is high and avm_waitrequest=0, capture avm_readdata (reads only), set rsp_error=0, and go to RESP; strobes drop the next cycle.
REQ-029 An 8-bit wait counter clears on entry to BUS and increments on each BUS cycle with waitrequest=1.
REQ-030 Abort: if waitrequest=1 in the TIMEOUT-th BUS cycle, go to RESP with rsp_error=1 and rsp_data=0; a strobe is never held more than TIMEOUT cycles.
REQ-031 Simultaneous event: if waitrequest falls in the TIMEOUT-th cycle, normal completion wins and no error is flagged.
REQ-032 RESP: rsp_valid=1; rsp_data and rsp_error are held stable until rsp_ready=1, then go to IDLE; the earliest next acceptance is the following cycle.
REQ-033 Outside BUS: avm_chipselect=0, avm_read=0, avm_write_n=1, and address, writedata and byteenable retain their last values.

Reset
REQ-034 Reset asynchronously forces: state=IDLE, cmd_ready=1 once released, rsp_valid=0, rsp_error=0, rsp_data=0, avm_chipselect=0, avm_read=0, avm_write_n=1, avm_address=0, avm_writedata=0, avm_byteenable=0, and wait counter=0.
REQ-035 Reset during BUS or RESP drops strobes immediately, without waiting for a clock edge; the pending transfer and its response are discarded, with no response issued.

Structure
REQ-036 Shared package avmm_pkg holds the FSM state encoding, the 32-bit data width constant and the TIMEOUT default.
REQ-037 Single flat module, with no sub-modules; the wait counter is inline.

Verification
REQ-038 Write 0x0000_03FF to address 0 with byteenable 0xF and waitrequest=0 -> avm_write_n low for exactly 1 cycle, then rsp_valid 1 cycle later with rsp_data=0 and rsp_error=0.
REQ-039 Read address 0 with waitrequest high for 3 cycles and readdata=0x0000_0155 on the 4th -> avm_read high for 4 cycles, then rsp_data=0x0000_0155 and rsp_error=0.
REQ-040 TIMEOUT=16 with waitrequest stuck high on a read -> avm_read high for exactly 16 cycles, then rsp_valid with rsp_error=1 and rsp_data=0.
REQ-041 waitrequest falls in cycle 16 with TIMEOUT=16 -> normal completion with rsp_error=0.
REQ-042 rsp_ready held low for 5 cycles with cmd_valid continuously high -> rsp fields stable, cmd_ready=0 throughout; the next command is accepted 1 cycle after the handshake.
REQ-043 Reset asserted mid-BUS -> strobes deassert asynchronously, with no rsp_valid after release and cmd_ready=1.
